// File: rtl/emissor_instrucao_pkg.sv
// Instruction word layout and FSM state encoding. The instruction decoder
// uses these same constants.
package pkg_instrucao;

  localparam int INSTR_W = 32;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 28;
  localparam int LIN_MSB  = 27;
  localparam int LIN_LSB  = 25;
  localparam int COL_MSB  = 24;
  localparam int COL_LSB  = 22;
  localparam int DADO_MSB = 21;
  localparam int DADO_LSB = 6;
  localparam int ID_MSB   = 5;
  localparam int ID_LSB   = 4;

  localparam int OPC_W  = OPC_MSB - OPC_LSB + 1;
  localparam int LIN_W  = LIN_MSB - LIN_LSB + 1;
  localparam int COL_W  = COL_MSB - COL_LSB + 1;
  localparam int DADO_W = DADO_MSB - DADO_LSB + 1;
  localparam int ID_W   = ID_MSB - ID_LSB + 1;

  typedef enum logic {
    OCIOSO   = 1'b0,
    VARRENDO = 1'b1
  } estado_t;

endpackage

// File: rtl/emissor_instrucao_empacota.sv
// Purely combinational field-to-word packer: the single place where the
// instruction layout is applied. Bits [3:0] are always zero.
module empacota_instrucao
  import pkg_instrucao::*;
(
  input  logic [OPC_W-1:0]   opcode,
  input  logic [LIN_W-1:0]   linha,
  input  logic [COL_W-1:0]   coluna,
  input  logic [DADO_W-1:0]  dado,
  input  logic [ID_W-1:0]    id_matriz,
  output logic [INSTR_W-1:0] palavra
);

  always_comb begin
    palavra                    = '0;
    palavra[OPC_MSB:OPC_LSB]   = opcode;
    palavra[LIN_MSB:LIN_LSB]   = linha;
    palavra[COL_MSB:COL_LSB]   = coluna;
    palavra[DADO_MSB:DADO_LSB] = dado;
    palavra[ID_MSB:ID_LSB]     = id_matriz;
  end

endmodule

// File: rtl/emissor_instrucao.sv
// Issues coprocessor instruction words over valid/ready; sweep mode expands one
// command into one word per matrix cell in row-major order.
module emissor_instrucao
  import pkg_instrucao::*;
#(
  parameter int unsigned LIN_MAX = 4,
  parameter int unsigned COL_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OPC_W-1:0]   cmd_opcode,
  input  logic [LIN_W-1:0]   cmd_linha,
  input  logic [COL_W-1:0]   cmd_coluna,
  input  logic [DADO_W-1:0]  cmd_dado,
  input  logic [ID_W-1:0]    cmd_id_matriz,
  input  logic               cmd_varredura,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic               ocupado
);

  if (LIN_MAX > 7 || COL_MAX > 7) begin : g_param_invalido
    $error("emissor_instrucao: LIN_MAX and COL_MAX must be in 0..7");
  end

  localparam logic [LIN_W-1:0] LIN_LIM   = LIN_W'(LIN_MAX);
  localparam logic [COL_W-1:0] COL_LIM   = COL_W'(COL_MAX);
  localparam bit               CELULA_UNICA = (LIN_MAX == 0) && (COL_MAX == 0);

  estado_t             estado;
  logic [LIN_W-1:0]    linha_q, linha_nx;
  logic [COL_W-1:0]    coluna_q, coluna_nx;
  logic [OPC_W-1:0]    opcode_q;
  logic [DADO_W-1:0]   dado_q;
  logic [ID_W-1:0]     id_q;
  logic                aceita, entrega, ultima;

  logic [OPC_W-1:0]    pk_opcode;
  logic [LIN_W-1:0]    pk_linha;
  logic [COL_W-1:0]    pk_coluna;
  logic [DADO_W-1:0]   pk_dado;
  logic [ID_W-1:0]     pk_id;
  logic [INSTR_W-1:0]  palavra;

  assign cmd_ready = (estado == OCIOSO) && (!instr_valid || instr_ready);
  assign aceita    = cmd_valid && cmd_ready;
  assign entrega   = instr_valid && instr_ready;
  assign ultima    = (linha_q == LIN_LIM) && (coluna_q == COL_LIM);
  assign ocupado   = (estado == VARRENDO) || instr_valid;

  always_comb begin
    coluna_nx = coluna_q + 1'b1;
    linha_nx  = linha_q;
    if (coluna_q == COL_LIM) begin
      coluna_nx = '0;
      linha_nx  = linha_q + 1'b1;
    end
  end

  // A new command takes priority; otherwise the packer builds the next sweep cell.
  always_comb begin
    if (aceita) begin
      pk_opcode = cmd_opcode;
      pk_dado   = cmd_dado;
      pk_id     = cmd_id_matriz;
      pk_linha  = cmd_varredura ? '0 : cmd_linha;
      pk_coluna = cmd_varredura ? '0 : cmd_coluna;
    end else begin
      pk_opcode = opcode_q;
      pk_dado   = dado_q;
      pk_id     = id_q;
      pk_linha  = linha_nx;
      pk_coluna = coluna_nx;
    end
  end

  empacota_instrucao u_empacota (
    .opcode    (pk_opcode),
    .linha     (pk_linha),
    .coluna    (pk_coluna),
    .dado      (pk_dado),
    .id_matriz (pk_id),
    .palavra   (palavra)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= OCIOSO;
      instr_valid <= 1'b0;
      instr       <= '0;
      linha_q     <= '0;
      coluna_q    <= '0;
    end else if (aceita) begin
      instr       <= palavra;
      instr_valid <= 1'b1;
      if (cmd_varredura) begin
        linha_q  <= '0;
        coluna_q <= '0;
        estado   <= CELULA_UNICA ? OCIOSO : VARRENDO;
      end
    end else if (entrega) begin
      if (estado == VARRENDO && !ultima) begin
        instr    <= palavra;
        linha_q  <= linha_nx;
        coluna_q <= coluna_nx;
      end else begin
        instr_valid <= 1'b0;
        estado      <= OCIOSO;
      end
    end
  end

  // Fields held constant across a sweep; pure data, so no reset.
  always_ff @(posedge clk) begin
    if (aceita) begin
      opcode_q <= cmd_opcode;
      dado_q   <= cmd_dado;
      id_q     <= cmd_id_matriz;
    end
  end

endmodule

// File: tb/tb_emissor_instrucao.sv
// Scoreboard bench for emissor_instrucao: expected words are queued at issue
// time and a monitor compares them against every instruction handshake.
module tb_emissor_instrucao;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_varredura;
  logic [3:0]  cmd_opcode;
  logic [2:0]  cmd_linha, cmd_coluna;
  logic [15:0] cmd_dado;
  logic [1:0]  cmd_id_matriz;
  logic        instr_valid, instr_ready, ocupado;
  logic [31:0] instr;

  logic        b_cmd_valid, b_cmd_ready, b_instr_valid, b_instr_ready, b_ocupado;
  logic [31:0] b_instr;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  emissor_instrucao #(.LIN_MAX(4), .COL_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_linha(cmd_linha), .cmd_coluna(cmd_coluna), .cmd_dado(cmd_dado),
    .cmd_id_matriz(cmd_id_matriz), .cmd_varredura(cmd_varredura),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ocupado(ocupado)
  );

  emissor_instrucao #(.LIN_MAX(0), .COL_MAX(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_opcode(4'hC),
    .cmd_linha(3'd5), .cmd_coluna(3'd6), .cmd_dado(16'h00FF),
    .cmd_id_matriz(2'd3), .cmd_varredura(1'b1),
    .instr_valid(b_instr_valid), .instr_ready(b_instr_ready), .instr(b_instr),
    .ocupado(b_ocupado)
  );

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] lin,
                                     input logic [2:0] col, input logic [15:0] d,
                                     input logic [1:0] id);
    return {op, lin, col, d, id, 4'b0000};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every accepted instruction word is checked against the queue head.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h, expected no word", instr);
      end else begin
        chk("word", instr, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [2:0] lin, input logic [2:0] col,
                      input logic [15:0] d, input logic [1:0] id, input logic varr);
    int n = 0;
    cmd_opcode = op; cmd_linha = lin; cmd_coluna = col;
    cmd_dado = d; cmd_id_matriz = id; cmd_varredura = varr;
    cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 200) begin
        chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_varredura = 1'b0; cmd_opcode = '0;
    cmd_linha = '0; cmd_coluna = '0; cmd_dado = '0; cmd_id_matriz = '0;
    instr_ready = 1'b0; b_cmd_valid = 1'b0; b_instr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single instruction, consumer always ready
    instr_ready = 1'b1;
    exp_q.push_back(32'h356AF350);
    send(4'd3, 3'd2, 3'd5, 16'hABCD, 2'd1, 1'b0);
    chk("t1_ocupado", 32'(ocupado), 32'd1);
    @(posedge clk); #1;
    chk("t1_valid_drop", 32'(instr_valid), 32'd0);
    chk("t1_queue", 32'(exp_q.size()), 32'd0);

    // Backpressure for 4 cycles
    instr_ready = 1'b0;
    exp_q.push_back(32'h356AF350);
    send(4'd3, 3'd2, 3'd5, 16'hABCD, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", 32'(instr_valid), 32'd1);
      chk("t2_hold_instr", instr, 32'h356AF350);
      chk("t2_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk); #1;
    instr_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_taken", 32'(instr_valid), 32'd0);
    chk("t2_queue", 32'(exp_q.size()), 32'd0);

    // Full sweep, consumer always ready: 25 words, row-major
    exp_q.push_back(32'h200001E0);
    for (int k = 1; k < 24; k++)
      exp_q.push_back(mk(4'd2, 3'(k / 5), 3'(k % 5), 16'h0007, 2'd2));
    exp_q.push_back(32'h290001E0);
    send(4'd2, 3'd3, 3'd3, 16'h0007, 2'd2, 1'b1);
    chk("t3_busy_cmd_ready", 32'(cmd_ready), 32'd0);
    drain("t3_drain", 60);
    chk("t3_cmd_ready_after", 32'(cmd_ready), 32'd1);
    chk("t3_ocupado_after", 32'(ocupado), 32'd0);

    // Sweep under random consumer stalls
    for (int k = 0; k < 25; k++)
      exp_q.push_back(mk(4'd5, 3'(k / 5), 3'(k % 5), 16'h1234, 2'd3));
    send(4'd5, 3'd0, 3'd0, 16'h1234, 2'd3, 1'b1);
    n = 0;
    do begin
      @(posedge clk); #1;
      instr_ready = 1'($urandom_range(0, 1));
      #1;
      chk("t4_cmd_ready", 32'(cmd_ready), (exp_q.size() != 0) ? 32'd0 : 32'd1);
      n++;
    end while (exp_q.size() != 0 && n < 400);
    chk("t4_drain", 32'(exp_q.size()), 32'd0);
    instr_ready = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a sweep
    for (int k = 0; k < 25; k++)
      exp_q.push_back(mk(4'd7, 3'(k / 5), 3'(k % 5), 16'h5A5A, 2'd0));
    send(4'd7, 3'd0, 3'd0, 16'h5A5A, 2'd0, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(instr_valid), 32'd0);
    chk("t5_rst_ocupado", 32'(ocupado), 32'd0);
    chk("t5_rst_instr", instr, 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle_after_rst", 32'(instr_valid), 32'd0);
    exp_q.push_back(32'h9E3FFFC0);
    send(4'd9, 3'd7, 3'd0, 16'hFFFF, 2'd0, 1'b0);
    drain("t5_drain", 10);

    // Back-to-back singles, one per cycle
    for (int i = 0; i < 4; i++) begin
      cmd_opcode    = 4'(4'hF + 4'(i * 11));
      cmd_linha     = 3'(i + 1);
      cmd_coluna    = 3'(6 - i);
      cmd_dado      = 16'(16'h1111 * (i + 1));
      cmd_id_matriz = 2'(i);
      cmd_varredura = 1'b0;
      cmd_valid     = 1'b1;
      @(negedge clk);
      chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
      exp_q.push_back(mk(4'(4'hF + 4'(i * 11)), 3'(i + 1), 3'(6 - i),
                         16'(16'h1111 * (i + 1)), 2'(i)));
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    drain("t6_drain", 10);

    // Single-cell sweep on the LIN_MAX=COL_MAX=0 instance
    b_cmd_valid = 1'b1;
    @(negedge clk);
    chk("t6b_cmd_ready", 32'(b_cmd_ready), 32'd1);
    @(posedge clk); #1;
    b_cmd_valid = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_instr_valid && b_instr_ready) begin
        cnt++;
        chk("t6b_word", b_instr, 32'hC0003FF0);
      end
    end
    chk("t6b_word_count", 32'(cnt), 32'd1);
    chk("t6b_ocupado", 32'(b_ocupado), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
